bblock_window: RTL
==================

Name: bblock_window

Overview:
- Upstream feeder for the Bblock neighbourhood cell.
- Accepts a framed serial bit stream plus a per-sample side bit x.
- Builds the 5-sample neighbourhood g1..g5 centred on g3 (index i=2 of the window), with zero padding at frame edges.
- Presents each window with its aligned x and a valid strobe, so the downstream cell evaluates exactly one window per sample.

Parameters:
- FRAME_LEN, 16, samples per frame; legal range 3..2^CNT_W.
- CNT_W, 5, width of the sample index counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  sample present on in_g/in_x
- in_sof  input  1  marks sample 0 of a frame; qualified by in_valid
- in_g  input  1  stream sample s[k]
- in_x  input  1  side bit x[k] for sample k
- in_ready  output  1  block accepts a sample this cycle
- out_valid  output  1  window outputs valid; one-cycle pulse per window
- g1,g2,g3,g4,g5  output  1 each  window bits s[k-2], s[k-1], s[k], s[k+1], s[k+2]
- x  output  1  x[k] aligned to centre g3
- out_last  output  1  with out_valid, marks the window centred on sample FRAME_LEN-1
- frame_err  output  1  one-cycle error pulse

Behaviour:
- Handshake: a sample is accepted when in_valid && in_ready. There is no output backpressure; the consumer is combinational.
- Padding rule: any s[j] with j<0 or j>=FRAME_LEN reads as 0. x is never padded.
- FSM states: IDLE, FILL, RUN, FLUSH.
- IDLE:
  - in_ready=1.
  - An accepted sample with in_sof=1 is stored as s[0]; cnt=1; go to FILL.
  - An accepted sample without in_sof is dropped and frame_err pulses next cycle.
- FILL:
  - in_ready=1.
  - Accept samples 1 and 2.
  - On accepting sample 2, register the window for centre 0; go to RUN.
- RUN:
  - in_ready=1.
  - Accepting sample k (3..FRAME_LEN-1) registers the window for centre k-2.
  - After accepting sample FRAME_LEN-1, go to FLUSH.
- FLUSH:
  - in_ready=0 for exactly 2 cycles.
  - Each cycle emits one window: centre FRAME_LEN-2, then FRAME_LEN-1, with g4/g5 zero-padded.
  - The second window also asserts out_last.
  - Then go to IDLE.
- Latency:
  - Window for centre k is valid the cycle after the acceptance of sample k+2, or the cycle after the corresponding FLUSH cycle.
  - With a gapless input, centre 0 appears 3 cycles after sample 0 is accepted.
- Bubbles: in_valid low in FILL/RUN holds all state; no output is produced.
- x alignment: x[k] travels in a 3-deep shift register alongside s. Output x equals x[k] of the centre sample.
- Mid-frame in_sof (accepted in FILL or RUN):
  - frame_err pulses.
  - All pending windows are discarded.
  - The sample becomes s[0] of a new frame; state goes to FILL, cnt=1.
- Storage: window storage is a 5-bit shift register, zero-cleared on each new frame so the leading g1/g2 pad reads 0.
- Reset (rst=1, synchronous): takes effect at the next clk edge, including mid-frame or in FLUSH.
  - State goes to IDLE and cnt=0.
  - Shift registers are cleared.
  - out_valid=0, out_last=0, frame_err=0, g1..g5=0, x=0.
  - in_ready=1 from the first cycle after reset deasserts.
- Registered outputs: all outputs except in_ready are registered. in_ready is decoded from state.
- Counter: cnt never wraps within a frame; FRAME_LEN-1 is the terminal index.

Test Plan:
1. FRAME_LEN=8, gapless frame s=1,0,1,1,0,0,1,0 (sof on s0), x=k[0], sample k accepted at cycle k.
   - Required: out_valid at cycles 3..10.
   - Cycle 3: g1..g5=0,0,1,0,1, x=0.
   - Cycle 10: g1..g5=0,1,0,0,0, x=1, out_last=1.
   - in_ready=0 at cycles 8–9.
2. Same frame with in_valid low on alternate cycles.
   - Required: identical window sequence, one out_valid per centre, no extra pulses; FLUSH still 2 cycles.
3. In IDLE, in_valid=1 with in_sof=0.
   - Required: sample dropped, frame_err=1 for one cycle, no out_valid.
   - A following sof frame processes normally.
4. New in_sof accepted at sample 4 of a frame.
   - Required: frame_err pulse; no window for the old centres 2–4 after the restart.
   - The next out_valid is centre 0 of the new frame with g1=g2=0.
5. rst asserted for one cycle during FLUSH.
   - Required: next cycle out_valid=0, out_last=0, g1..g5=0, x=0, in_ready=1, state IDLE.
   - A fresh frame then reproduces scenario 1 outputs.
6. FRAME_LEN=3, s=1,1,1.
   - Required: exactly 3 windows: 0,0,1,1,1 / 0,1,1,1,0 / 1,1,1,0,0.
   - out_last on the third window only.

Source files
------------

// File: rtl/bblock_window.sv
// Bblock window feeder: turns a framed serial stream into one registered
// 5-sample neighbourhood (g1..g5, centre g3) per sample, zero-padded at frame edges.
module bblock_window #(
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_sof,
  input  logic in_g,
  input  logic in_x,
  output logic in_ready,
  output logic out_valid,
  output logic g1,
  output logic g2,
  output logic g3,
  output logic g4,
  output logic g5,
  output logic x,
  output logic out_last,
  output logic frame_err
);

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] IDX_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] IDX_TWO  = CNT_W'(2);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [4:0]       sr, sr_nx;    // sr[0] holds the newest sample
  logic [2:0]       xs, xs_nx;    // xs[2] is x of the current centre
  logic [4:0]       win_q, win_nx;
  logic             x_q, x_nx;
  logic             ov_nx, last_nx, err_nx;
  logic             accept;

  assign in_ready = (state != FLUSH);
  assign accept   = in_valid && in_ready;

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_nx = state;
    cnt_nx   = cnt;
    sr_nx    = sr;
    xs_nx    = xs;
    ov_nx    = 1'b0;
    last_nx  = 1'b0;
    err_nx   = 1'b0;

    unique case (state)
      IDLE: begin
        if (accept) begin
          if (in_sof) begin
            sr_nx    = {4'b0000, in_g};
            xs_nx    = {2'b00, in_x};
            cnt_nx   = IDX_ONE;
            state_nx = FILL;
          end else begin
            err_nx = 1'b1;
          end
        end
      end

      FILL, RUN: begin
        if (accept) begin
          if (in_sof) begin
            // Restart: pending windows are dropped, sample becomes s[0].
            err_nx   = 1'b1;
            sr_nx    = {4'b0000, in_g};
            xs_nx    = {2'b00, in_x};
            cnt_nx   = IDX_ONE;
            state_nx = FILL;
          end else begin
            sr_nx = {sr[3:0], in_g};
            xs_nx = {xs[1:0], in_x};
            ov_nx = (cnt >= IDX_TWO);
            if (cnt == LAST_IDX) begin
              cnt_nx   = '0;
              state_nx = FLUSH;
            end else begin
              cnt_nx = cnt + IDX_ONE;
              if (cnt == IDX_TWO) state_nx = RUN;
            end
          end
        end
      end

      FLUSH: begin
        // Shift in trailing zero pad; cnt reused as the flush phase.
        sr_nx = {sr[3:0], 1'b0};
        xs_nx = {xs[1:0], 1'b0};
        ov_nx = 1'b1;
        if (cnt == '0) begin
          cnt_nx = IDX_ONE;
        end else begin
          last_nx  = 1'b1;
          cnt_nx   = '0;
          state_nx = IDLE;
        end
      end

      default: state_nx = IDLE;
    endcase

    win_nx = ov_nx ? sr_nx : 5'b00000;
    x_nx   = ov_nx ? xs_nx[2] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: shift registers are cleared on reset too, so the first frame's pads read 0.
      state     <= IDLE;
      cnt       <= '0;
      sr        <= '0;
      xs        <= '0;
      win_q     <= '0;
      x_q       <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      sr        <= sr_nx;
      xs        <= xs_nx;
      win_q     <= win_nx;
      x_q       <= x_nx;
      out_valid <= ov_nx;
      out_last  <= last_nx;
      frame_err <= err_nx;
    end
  end

  assign g1 = win_q[4];
  assign g2 = win_q[3];
  assign g3 = win_q[2];
  assign g4 = win_q[1];
  assign g5 = win_q[0];
  assign x  = x_q;

endmodule
